// File: rtl/pe_array_pkg.sv
// Shared constants and FSM state type for the 4x4 systolic PE array sequencer.
package pe_array_pkg;
    localparam int N     = 4;
    localparam int ACC_W = 32;
    localparam int LEN_W = 8;
    localparam int FLUSH = 2*(N-1)+1;
    localparam int IDX_W = $clog2(N*N);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;
endpackage

// File: rtl/pe_array_drain_result_out_reg.sv
// One-entry valid/ready output register carrying a PE sum, its index and the last flag.
module result_out_reg #(
    parameter int DATA_W = pe_array_pkg::ACC_W,
    parameter int IDX_W  = pe_array_pkg::IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_last,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_idx,
    output logic              m_last
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              last_q, last_d;

    // The caller only asserts load when the slot is empty or being accepted.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            idx_d   = in_idx;
            last_d  = in_last;
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_idx   = idx_q;
    assign m_last  = last_q;
endmodule

// File: rtl/pe_array_drain.sv
// Runs the PE array for k_len operands plus pipeline flush, then streams all
// N*N accumulated sums out over a valid/ready port.
module pe_array_drain #(
    parameter int N     = pe_array_pkg::N,
    parameter int ACC_W = pe_array_pkg::ACC_W,
    parameter int LEN_W = pe_array_pkg::LEN_W,
    parameter int FLUSH = pe_array_pkg::FLUSH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_W-1:0]       k_len,
    output logic                   busy,
    output logic                   feed_req,
    output logic                   arr_en,
    output logic [$clog2(N*N)-1:0] out_sel,
    input  logic [ACC_W-1:0]       arr_result,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [ACC_W-1:0]       m_data,
    output logic [$clog2(N*N)-1:0] m_idx,
    output logic                   m_last,
    output logic                   done
);
    import pe_array_pkg::*;

    localparam int IDX_W = $clog2(N*N);
    localparam int CNT_W = LEN_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N*N-1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt, cnt_end;
    logic [IDX_W-1:0] rd_q, rd_d;
    logic             rd_all_q, rd_all_d;
    logic             busy_q, busy_d;
    logic             arr_en_q, arr_en_d;
    logic             feed_req_q, feed_req_d;
    logic             done_q, done_d;
    logic             load;

    assign cnt_nxt = cnt_q + CNT_W'(1);
    assign cnt_end = CNT_W'(k_q) + CNT_W'(FLUSH - 1);
    assign load    = (state_q == DRAIN) && !rd_all_q && (!m_valid || m_ready);

    // Enable/feed are registered, so they lead the state by one decision:
    // the value computed here is what the array sees next cycle.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        rd_all_d   = rd_all_q;
        busy_d     = busy_q;
        arr_en_d   = 1'b0;
        feed_req_d = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    k_d      = k_len;
                    cnt_d    = '0;
                    rd_d     = '0;
                    rd_all_d = 1'b0;
                    busy_d   = 1'b1;
                    if (k_len == '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d    = COMPUTE;
                        arr_en_d   = 1'b1;
                        feed_req_d = 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (cnt_q == cnt_end) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d      = cnt_nxt;
                    arr_en_d   = 1'b1;
                    feed_req_d = cnt_nxt < CNT_W'(k_q);
                end
            end
            DRAIN: begin
                // rd_all stops out_sel from wrapping once the last PE is loaded.
                if (load) begin
                    if (rd_q == LAST_IDX) rd_all_d = 1'b1;
                    else                  rd_d     = rd_q + IDX_W'(1);
                end
                if (m_valid && m_ready && m_last) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rd_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            rd_q       <= '0;
            rd_all_q   <= 1'b0;
            busy_q     <= 1'b0;
            arr_en_q   <= 1'b0;
            feed_req_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            rd_all_q   <= rd_all_d;
            busy_q     <= busy_d;
            arr_en_q   <= arr_en_d;
            feed_req_q <= feed_req_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign arr_en   = arr_en_q;
    assign feed_req = feed_req_q;
    assign done     = done_q;
    assign out_sel  = rd_q;

    result_out_reg #(
        .DATA_W (ACC_W),
        .IDX_W  (IDX_W)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .in_data (arr_result),
        .in_idx  (rd_q),
        .in_last (rd_q == LAST_IDX),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_idx   (m_idx),
        .m_last  (m_last)
    );
endmodule

// File: tb/tb_pe_array_drain.sv
// Bench for pe_array_drain: accumulating array model, randomized backpressure,
// and a job-level reference for enable counts, beat stream and latency.
module tb_pe_array_drain;
    localparam int N     = 4;
    localparam int ACC_W = 32;
    localparam int LEN_W = 8;
    localparam int FLUSH = 7;
    localparam int IDX_W = 4;
    localparam int NPE   = N*N;

    logic             clk = 1'b0;
    logic             rst_n, start, m_ready;
    logic [LEN_W-1:0] k_len;
    logic             busy, feed_req, arr_en, m_valid, m_last, done;
    logic [IDX_W-1:0] out_sel, m_idx;
    logic [ACC_W-1:0] arr_result, m_data;

    logic [ACC_W-1:0] sums [NPE];
    int cyc = 0, errors = 0, checks = 0, ready_mode = 0;
    int en_total = 0, feed_total = 0, en_rise_cyc = -1;
    int done_total = 0, done_cyc = -1, stab_err = 0;
    logic [IDX_W-1:0] q_idx [$];
    logic [ACC_W-1:0] q_data [$];
    logic             q_last [$];
    bit               held = 1'b0, prev_en = 1'b0;
    logic [ACC_W-1:0] h_data;
    logic [IDX_W-1:0] h_idx, h_sel;
    logic             h_last;

    pe_array_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_len      (k_len),
        .busy       (busy),
        .feed_req   (feed_req),
        .arr_en     (arr_en),
        .out_sel    (out_sel),
        .arr_result (arr_result),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_idx      (m_idx),
        .m_last     (m_last),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Array model: every enabled cycle PE i adds i+1; preload makes a 4-operand job end at 100+i.
    initial begin
        for (int i = 0; i < NPE; i++) sums[i] = ACC_W'(100 + i - (i + 1) * (4 + FLUSH));
        forever begin
            @(posedge clk);
            if (arr_en === 1'b1)
                for (int i = 0; i < NPE; i++) sums[i] = sums[i] + ACC_W'(i + 1);
        end
    end
    assign arr_result = sums[out_sel];

    initial begin
        bit pat [6];
        int ph;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin m_ready = pat[ph]; ph = (ph + 1) % 6; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: counts enables, records accepted beats, flags any change while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            held    = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (arr_en) en_total++;
            if (feed_req) feed_total++;
            if (arr_en && !prev_en) en_rise_cyc = cyc;
            prev_en = arr_en;
            if (held && (!m_valid || m_data !== h_data || m_idx !== h_idx ||
                         m_last !== h_last || out_sel !== h_sel)) stab_err++;
            held   = m_valid && !m_ready;
            h_data = m_data;
            h_idx  = m_idx;
            h_last = m_last;
            h_sel  = out_sel;
            if (m_valid && m_ready) begin
                q_idx.push_back(m_idx);
                q_data.push_back(m_data);
                q_last.push_back(m_last);
            end
            if (done) begin
                done_total++;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"},     64'(busy),     64'd0);
        check_output({tag, "_feed_req"}, 64'(feed_req), 64'd0);
        check_output({tag, "_arr_en"},   64'(arr_en),   64'd0);
        check_output({tag, "_out_sel"},  64'(out_sel),  64'd0);
        check_output({tag, "_m_valid"},  64'(m_valid),  64'd0);
        check_output({tag, "_m_data"},   64'(m_data),   64'd0);
        check_output({tag, "_m_idx"},    64'(m_idx),    64'd0);
        check_output({tag, "_m_last"},   64'(m_last),   64'd0);
        check_output({tag, "_done"},     64'(done),     64'd0);
    endtask

    task automatic apply_stimulus(input int k, input int mode, input bit repulse);
        int en0, fd0, q0, se0, d0, t0, bad, nb;
        bit got;
        logic [ACC_W-1:0] snap [NPE];
        logic [ACC_W-1:0] exp_data;
        ready_mode = mode;
        @(posedge clk); #1;
        en0 = en_total; fd0 = feed_total; q0 = q_idx.size(); se0 = stab_err; d0 = done_total;
        for (int i = 0; i < NPE; i++) snap[i] = sums[i];
        check_output($sformatf("idle_k%0d", k), 64'(busy), 64'd0);
        start = 1'b1;
        k_len = LEN_W'(k);
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        k_len = '0;
        if (repulse) begin
            repeat (2) @(posedge clk);
            #1 start = 1'b1; k_len = LEN_W'(50);
            @(posedge clk); #1 start = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (m_valid) break;
                @(posedge clk); #1;
            end
            start = 1'b1; k_len = LEN_W'(50);
            @(posedge clk); #1 start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done_total > d0) begin got = 1'b1; break; end
        end
        check_output($sformatf("done_seen_k%0d", k), 64'(got), 64'd1);
        repeat (3) @(negedge clk);
        check_output($sformatf("en_count_k%0d", k), 64'(en_total - en0), 64'(k + FLUSH * (k > 0)));
        check_output($sformatf("feed_count_k%0d", k), 64'(feed_total - fd0), 64'(k));
        if (k > 0) check_output($sformatf("en_first_k%0d", k), 64'(en_rise_cyc), 64'(t0 + 1));
        nb = q_idx.size() - q0;
        check_output($sformatf("beat_count_k%0d", k), 64'(nb), 64'(NPE));
        bad = 0;
        for (int j = 0; j < nb && j < NPE; j++) begin
            exp_data = snap[j] + ACC_W'((j + 1) * (k + FLUSH * (k > 0)));
            if (q_idx[q0+j] !== IDX_W'(j) || q_data[q0+j] !== exp_data ||
                q_last[q0+j] !== (j == NPE - 1)) begin
                bad++;
                $display("[TB] beat %0d: idx=%0d data=%0h last=%0b want data=%0h",
                         j, q_idx[q0+j], q_data[q0+j], q_last[q0+j], exp_data);
            end
        end
        check_output($sformatf("beat_content_k%0d", k), 64'(bad), 64'd0);
        check_output($sformatf("stall_stable_k%0d", k), 64'(stab_err - se0), 64'd0);
        check_output($sformatf("done_pulses_k%0d", k), 64'(done_total - d0), 64'd1);
        if (mode == 0)
            check_output($sformatf("latency_k%0d", k), 64'(done_cyc - t0), 64'(k + FLUSH * (k > 0) + NPE + 2));
        check_output($sformatf("busy_after_k%0d", k), 64'(busy), 64'd0);
    endtask

    initial begin
        bit got;
        rst_n = 1'b0;
        start = 1'b0;
        k_len = '0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;

        apply_stimulus(4, 0, 1'b0);
        apply_stimulus($urandom_range(1, 20), 1, 1'b0);
        apply_stimulus(0, 0, 1'b0);
        apply_stimulus(4, 0, 1'b1);

        // Abort a job with reset while beat 7 is on the bus.
        ready_mode = 0;
        @(posedge clk); #1 start = 1'b1; k_len = LEN_W'(3);
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_valid && m_idx == IDX_W'(7)) begin got = 1'b1; break; end
        end
        check_output("reach_beat7", 64'(got), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midjob_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(2, 0, 1'b0);

        apply_stimulus(255, 2, 1'b0);
        repeat (2) apply_stimulus($urandom_range(0, 30), 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
